// File: rtl/aoi_preimage_scanner_pkg.sv
// aoi_preimage_scanner_pkg: shared widths, state encoding and expected match totals
package aoi_preimage_scanner_pkg;
  localparam int VEC_W = 5;
  localparam int CNT_W = 6;
  localparam int ONES_TOTAL = 17;
  localparam int ZEROS_TOTAL = 15;
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, HOLD = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/aoi_preimage_scanner_aoi5_eval.sv
// aoi5_eval: gate-level f = ~((a | ~b) & ((c & d) | e))
module aoi5_eval (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  input  logic e,
  output logic f
);
  logic nb, ab, cd, cde;
  not  g0 (nb, b);
  or   g1 (ab, a, nb);
  and  g2 (cd, c, d);
  or   g3 (cde, cd, e);
  nand g4 (f, ab, cde);
endmodule

// File: rtl/aoi_preimage_scanner.sv
// aoi_preimage_scanner: sweeps all AOI inputs and streams those whose output equals target
module aoi_preimage_scanner
  import aoi_preimage_scanner_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             target,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [VEC_W-1:0] m_vec,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count
);
  state_t state, state_n;
  logic [VEC_W-1:0] idx;
  logic target_q, f, match, last;
  aoi5_eval u_eval (.a(idx[4]), .b(idx[3]), .c(idx[2]), .d(idx[1]), .e(idx[0]), .f(f));
  assign match = f == target_q;
  assign last = &idx;
  assign busy = state == SCAN || state == HOLD;
  assign done = state == DONE;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (start ? SCAN : IDLE) :
              state == SCAN ? (match ? HOLD : last ? DONE : SCAN) :
              state == HOLD ? (m_ready ? (last ? DONE : SCAN) : HOLD) : IDLE;
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  // idx only advances once the current vector is finished, so it never wraps
  always_ff @(posedge clk)
    if (rst) begin
      idx <= '0;
      target_q <= 1'b0;
      count <= '0;
      m_vec <= '0;
      m_valid <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        target_q <= target;
        idx <= '0;
        count <= '0;
      end
      if (state == SCAN && match) begin
        m_vec <= idx;
        m_valid <= 1'b1;
        count <= count + 1'b1;
      end
      if (((state == SCAN && !match) || (state == HOLD && m_ready)) && !last) idx <= idx + 1'b1;
      if (state == HOLD && m_ready) m_valid <= 1'b0;
    end
endmodule

// File: tb/tb_aoi_preimage_scanner.sv
// tb_aoi_preimage_scanner: scoreboard bench for the AOI preimage scanner
module tb_aoi_preimage_scanner;
  import aoi_preimage_scanner_pkg::*;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, target = 1'b0, m_ready = 1'b1;
  logic m_valid, busy, done;
  logic [4:0] m_vec;
  logic [5:0] count;
  int tests = 0, fails = 0, edges = 0, done_cnt = 0, done_edge = 0, e0 = 0, sc = 0;
  bit stall_mode = 0, prev_stall = 0;
  logic [4:0] prev_vec;
  logic [4:0] exp_q[$];
  logic [4:0] got[$];

  aoi_preimage_scanner dut (
    .clk(clk), .rst(rst), .start(start), .target(target), .m_valid(m_valid),
    .m_ready(m_ready), .m_vec(m_vec), .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  function automatic bit f_ref(logic [4:0] v);
    return ~((v[4] | ~v[3]) & ((v[2] & v[1]) | v[0]));
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // holds m_ready low for 4 cycles at the start of every beat
  always @(posedge clk) begin
    #1;
    if (stall_mode && m_valid && sc < 4) begin
      m_ready = 1'b0;
      sc++;
    end else begin
      m_ready = 1'b1;
      sc = 0;
    end
  end

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      done_edge = edges;
    end
    if (prev_stall) begin
      chk("stall_valid", {31'b0, m_valid}, 1);
      chk("stall_vec", {27'b0, m_vec}, {27'b0, prev_vec});
    end
    prev_stall = m_valid && !m_ready && !rst;
    prev_vec = m_vec;
    if (m_valid && m_ready && !rst) begin
      got.push_back(m_vec);
      if (exp_q.size() == 0) chk("unexpected_beat", {27'b0, m_vec}, 32'hffff_ffff);
      else chk("beat_vec", {27'b0, m_vec}, {27'b0, exp_q.pop_front()});
    end
  end

  task automatic push_expect(bit t);
    for (int v = 0; v < 32; v++)
      if (f_ref(5'(v)) == t) exp_q.push_back(5'(v));
  endtask

  task automatic start_scan(bit t);
    got.delete();
    target = t;
    start = 1'b1;
    tick();
    start = 1'b0;
    e0 = edges;
    push_expect(t);
  endtask

  task automatic wait_done();
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < 400 && done_cnt == d0; i++) tick();
    chk("done_timeout", {31'b0, done_cnt != d0}, 1);
  endtask

  task automatic finish_scan(string tag, int m, int first, int last_v, int rel);
    wait_done();
    chk({tag, "_done_edge"}, done_edge - e0, rel);
    chk({tag, "_count"}, {26'b0, count}, m);
    chk({tag, "_beats"}, got.size(), m);
    chk({tag, "_first"}, got.size() > 0 ? {27'b0, got[0]} : 32'hffff_ffff, first);
    chk({tag, "_last"}, got.size() > 0 ? {27'b0, got[$]} : 32'hffff_ffff, last_v);
    chk({tag, "_queue_empty"}, exp_q.size(), 0);
    chk({tag, "_busy_idle"}, {31'b0, busy}, 0);
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_valid", {31'b0, m_valid}, 0);
    chk("rst_vec", {27'b0, m_vec}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_count", {26'b0, count}, 0);
    repeat (3) tick();
    chk("idle_busy", {31'b0, busy}, 0);
    chk("idle_valid", {31'b0, m_valid}, 0);

    start_scan(1'b1);
    chk("scan_busy", {31'b0, busy}, 1);
    finish_scan("t1", ONES_TOTAL, 5'h00, 5'h1C, 32 + ONES_TOTAL);

    start_scan(1'b0);
    finish_scan("t0", ZEROS_TOTAL, 5'h01, 5'h1F, 32 + ZEROS_TOTAL);

    stall_mode = 1;
    start_scan(1'b1);
    finish_scan("bp", ONES_TOTAL, 5'h00, 5'h1C, 117);

    start_scan(1'b1);
    for (int i = 0; i < 200 && !(got.size() == 4 && m_valid); i++) tick();
    chk("midhold_reached", {31'b0, m_valid}, 1);
    rst = 1'b1;
    stall_mode = 0;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", {31'b0, m_valid}, 0);
    chk("mid_rst_count", {26'b0, count}, 0);
    chk("mid_rst_busy", {31'b0, busy}, 0);
    chk("mid_rst_vec", {27'b0, m_vec}, 0);
    exp_q.delete();
    tick();
    start_scan(1'b1);
    finish_scan("after_rst", ONES_TOTAL, 5'h00, 5'h1C, 32 + ONES_TOTAL);

    start_scan(1'b1);
    repeat (10) tick();
    target = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (25) tick();
    start = 1'b1;
    wait_done();
    chk("ign_done_edge", done_edge - e0, 32 + ONES_TOTAL);
    chk("ign_count", {26'b0, count}, ONES_TOTAL);
    chk("ign_beats", got.size(), ONES_TOTAL);
    chk("ign_queue_empty", exp_q.size(), 0);
    chk("restart_idle", {31'b0, busy}, 0);
    got.delete();
    push_expect(1'b0);
    tick();
    start = 1'b0;
    e0 = edges;
    chk("restart_busy", {31'b0, busy}, 1);
    chk("restart_gap", e0 - done_edge, 2);
    finish_scan("restart_t0", ZEROS_TOTAL, 5'h01, 5'h1F, 32 + ZEROS_TOTAL);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
